// File: rtl/valid_burst_gen.sv
// Expands each accepted trigger into N_COUNT single-cycle o_valid strobes separated by
// N_GAP idle cycles; up to N_PEND triggers wait in a counter-based queue.
module valid_burst_gen #(
    parameter int N_COUNT = 5,
    parameter int N_GAP   = 1,
    parameter int N_PEND  = 3
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_trigger,
    input  logic                          i_enable,
    output logic                          o_ready,
    output logic                          o_valid,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(N_PEND+1)-1:0]   o_pending,
    output logic                          o_overflow
);

    localparam int SW = $clog2(N_COUNT + 1);
    localparam int GW = (N_GAP > 0) ? $clog2(N_GAP + 1) : 1;
    localparam int PW = $clog2(N_PEND + 1);

    localparam logic [SW-1:0] LAST_STROBE = SW'(N_COUNT - 1);
    localparam logic [GW-1:0] GAP_MAX     = GW'(N_GAP);
    localparam logic [PW-1:0] PEND_MAX    = PW'(N_PEND);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP,
        DONE
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   strobe_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic [PW-1:0]   pending_q;
    logic [PW-1:0]   pending_d;
    logic            overflow_q;
    logic            accept;
    logic            start;

    assign accept = i_trigger & o_ready;
    assign start  = (state_q == IDLE) && (pending_q != '0) && i_enable;

    // An accept and a burst start on the same edge cancel out.
    always_comb begin
        pending_d = pending_q;
        if (accept && !start) begin
            pending_d = pending_q + PW'(1);
        end else if (!accept && start) begin
            pending_d = pending_q - PW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            strobe_cnt_q <= '0;
            gap_cnt_q    <= '0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (i_trigger && !o_ready) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= STROBE;
                        strobe_cnt_q <= '0;
                    end
                end
                STROBE: begin
                    if (strobe_cnt_q == LAST_STROBE) begin
                        state_q <= DONE;
                    end else if ((N_GAP == 0) && i_enable) begin
                        strobe_cnt_q <= strobe_cnt_q + SW'(1);
                    end else begin
                        // With N_GAP=0 this GAP visit only happens while paused.
                        state_q      <= GAP;
                        strobe_cnt_q <= strobe_cnt_q + SW'(1);
                        gap_cnt_q    <= GW'(1);
                    end
                end
                GAP: begin
                    if ((gap_cnt_q >= GAP_MAX) && i_enable) begin
                        state_q <= STROBE;
                    end else if (gap_cnt_q < GAP_MAX) begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_valid    = (state_q == STROBE);
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_ready    = (pending_q != PEND_MAX);
    assign o_pending  = pending_q;
    assign o_overflow = overflow_q;

endmodule
